// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : EX-stage iterative multiply/divide unit with HI/LO registers.
//            MULTU/DIVU take DATA_W cycles each. Define MULDIV_SIGNED_EN to
//            also support MULT/DIV.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid_in,
    input  logic [5:0]        funct_in,
    input  logic [DATA_W-1:0] rs_val_in,
    input  logic [DATA_W-1:0] rt_val_in,
    input  logic              flush_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              div_by_zero_out,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int              CNT_W          = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_LAST_STEP   = CNT_W'(DATA_W - 1);
    localparam logic [5:0]      c_FUNCT_MULT   = 6'h18;
    localparam logic [5:0]      c_FUNCT_MULTU  = 6'h19;
    localparam logic [5:0]      c_FUNCT_DIV    = 6'h1A;
    localparam logic [5:0]      c_FUNCT_DIVU   = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [2*DATA_W-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]       opnd_q, opnd_d;
    logic [DATA_W-1:0]       hi_q, hi_d;
    logic [DATA_W-1:0]       lo_q, lo_d;
    logic                    busy_q, done_q, dbz_q, dbz_d;

    logic                    w_is_mul, w_is_div, w_start;
    logic [DATA_W-1:0]       w_rs_op, w_rt_op;
    logic [DATA_W:0]         w_mul_sum, w_div_shift;
    logic [2*DATA_W-1:0]     w_mul_step, w_div_step, w_mul_res;
    logic [DATA_W-1:0]       w_div_rem, w_div_hi, w_div_lo;
    logic                    w_div_ge;

    // acc_q holds {partial product, remaining multiplier} for MUL and
    // {partial remainder, dividend/quotient} for DIV; opnd_q holds the other operand.
    assign w_mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                      + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
    assign w_mul_step = {w_mul_sum, acc_q[DATA_W-1:1]};

    assign w_div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, opnd_q});
    assign w_div_rem   = w_div_ge ? DATA_W'(w_div_shift - {1'b0, opnd_q})
                                  : w_div_shift[DATA_W-1:0];
    assign w_div_step  = {w_div_rem, acc_q[DATA_W-2:0], w_div_ge};

`ifdef MULDIV_SIGNED_EN
    logic w_signed_op, w_rs_neg, w_rt_neg;
    logic neg_lo_q, neg_hi_q;

    assign w_is_mul    = (funct_in == c_FUNCT_MULTU) || (funct_in == c_FUNCT_MULT);
    assign w_is_div    = (funct_in == c_FUNCT_DIVU)  || (funct_in == c_FUNCT_DIV);
    assign w_signed_op = (funct_in == c_FUNCT_MULT)  || (funct_in == c_FUNCT_DIV);
    assign w_rs_neg    = w_signed_op & rs_val_in[DATA_W-1];
    assign w_rt_neg    = w_signed_op & rt_val_in[DATA_W-1];
    assign w_rs_op     = w_rs_neg ? (~rs_val_in + 1'b1) : rs_val_in;
    assign w_rt_op     = w_rt_neg ? (~rt_val_in + 1'b1) : rt_val_in;

    // neg_lo_q: product/quotient sign; neg_hi_q: remainder follows the dividend.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (w_start) begin
            neg_lo_q <= w_rs_neg ^ w_rt_neg;
            neg_hi_q <= w_rs_neg;
        end
    end

    assign w_mul_res = neg_lo_q ? (~w_mul_step + 1'b1) : w_mul_step;
    assign w_div_lo  = neg_lo_q ? (~w_div_step[DATA_W-1:0] + 1'b1)
                                : w_div_step[DATA_W-1:0];
    assign w_div_hi  = neg_hi_q ? (~w_div_step[2*DATA_W-1:DATA_W] + 1'b1)
                                : w_div_step[2*DATA_W-1:DATA_W];
`else
    assign w_is_mul  = (funct_in == c_FUNCT_MULTU);
    assign w_is_div  = (funct_in == c_FUNCT_DIVU);
    assign w_rs_op   = rs_val_in;
    assign w_rt_op   = rt_val_in;
    assign w_mul_res = w_mul_step;
    assign w_div_lo  = w_div_step[DATA_W-1:0];
    assign w_div_hi  = w_div_step[2*DATA_W-1:DATA_W];
`endif

    assign w_start = op_valid_in && !flush_in && (w_is_mul || w_is_div)
                  && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (w_start) begin
                    count_d = '0;
                    if (w_is_mul) begin
                        state_d = MUL;
                        acc_d   = {{DATA_W{1'b0}}, w_rt_op};
                        opnd_d  = w_rs_op;
                    end else begin
                        acc_d  = {{DATA_W{1'b0}}, w_rs_op};
                        opnd_d = w_rt_op;
                        if (rt_val_in == '0) begin
                            // Divide by zero skips iteration entirely.
                            state_d = DONE;
                            hi_d    = rs_val_in;
                            lo_d    = '1;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d = DIV;
                        end
                    end
                end
            end
            MUL: begin
                if (flush_in) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = w_mul_step;
                    count_d = count_q + 1'b1;
                    if (count_q == c_LAST_STEP) begin
                        state_d      = DONE;
                        {hi_d, lo_d} = w_mul_res;
                    end
                end
            end
            DIV: begin
                if (flush_in) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = w_div_step;
                    count_d = count_q + 1'b1;
                    if (count_q == c_LAST_STEP) begin
                        state_d = DONE;
                        hi_d    = w_div_hi;
                        lo_d    = w_div_lo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d == MUL) || (state_d == DIV);
            done_q  <= (state_d == DONE);
            dbz_q   <= dbz_d;
        end
    end

    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign div_by_zero_out = dbz_q;
    assign hi_out          = hi_q;
    assign lo_out          = lo_q;

endmodule

`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- EX-stage iterative multiply/divide unit that consumes operands and funct from the ID/EX pipeline register.
- Executes MULTU/DIVU (optionally MULT/DIV) over DATA_W cycles and holds results in HI/LO.
- busy_out feeds the hazard unit, which stalls dependent MFHI/MFLO and any further mul/div instructions.
- hi_out/lo_out feed the EX result mux for MFHI/MFLO.

Parameters:
- DATA_W, 32, operand/HI/LO width. Iteration count = DATA_W. Counter width = clog2(DATA_W).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op_valid_in  in  1  ID/EX holds an R-type instruction this cycle (from ALUOp/RegWrite decode)
- funct_in  in  6  ID/EX funct field
- rs_val_in  in  DATA_W  ID/EX RD1 (multiplicand/dividend)
- rt_val_in  in  DATA_W  ID/EX RD2 (multiplier/divisor)
- flush_in  in  1  abort in-flight operation (exception/branch squash)
- busy_out  out  1  registered; high while iterating
- done_out  out  1  one-cycle pulse; HI/LO updated
- div_by_zero_out  out  1  one-cycle pulse with done_out for divide with rt=0
- hi_out  out  DATA_W  HI register
- lo_out  out  DATA_W  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, HI=LO=0. busy_out, done_out and div_by_zero_out are 0. All internal operand/accumulator registers are cleared. Reset mid-operation discards the operation immediately.
- States: IDLE, MUL, DIV, DONE.
- Accept: in IDLE or DONE, op_valid_in=1 and flush_in=0.
  - funct 0x19 (MULTU) -> MUL. funct 0x1B (DIVU) -> DIV.
  - Any other funct: ignored, no state change.
  - On accept: rs/rt captured, count=0.
- MUL: one shift-add step per edge. After step DATA_W-1 (count=DATA_W-1): {HI,LO} = 64-bit unsigned product, state -> DONE.
- DIV: one restoring-division step per edge. After step DATA_W-1: LO = quotient, HI = remainder, state -> DONE.
- DIV with rt=0 at accept: next edge goes straight to DONE with HI = rs, LO = all-ones, div_by_zero_out=1 during DONE. No iterations are performed.
- DONE: lasts exactly one cycle. done_out=1. Returns to IDLE unless a new op is accepted that edge.
- Latency: accept at edge N -> busy_out high for cycles after N through edge N+DATA_W. done_out high the following cycle with HI/LO valid. DATA_W=32: busy for 32 cycles, done on cycle 33.
- busy_out = 1 exactly in MUL/DIV (registered from next-state).
- op_valid_in while busy: ignored. The hazard unit guarantees a stall, so no queueing is provided.
- flush_in=1 in MUL/DIV: next edge -> IDLE. HI/LO unchanged, no done_out.
- flush_in=1 in IDLE/DONE: blocks acceptance that cycle.
- flush_in and accept in the same cycle: flush wins.
- HI/LO change only at final-step/DONE entry or reset.
- Arithmetic is full width, with no truncation before HI/LO split. Product is exactly 2*DATA_W bits.

Optional Feature:
- Macro: MULDIV_SIGNED_EN
- Defined:
  - funct 0x18 (MULT) and 0x1A (DIV) are also accepted.
  - Operands are converted to magnitudes at accept; the sign fix is applied at the final step, so latency is identical.
  - Product sign = rs[MSB]^rt[MSB]. Quotient sign = rs^rt sign. Remainder takes the dividend sign.
  - DIV by zero behaves as DIVU by zero.
- Undefined: 0x18/0x1A are ignored like any non-mul/div funct (no busy, no done). No signed logic is synthesized.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy_out high exactly 32 cycles; done_out pulse on cycle 33; HI=0xFFFFFFFE, LO=0x00000001.
- DIVU rs=100 rt=7 -> after 32 busy cycles: done_out=1, LO=14, HI=2, div_by_zero_out=0.
- DIVU rs=5 rt=0 -> no busy cycles; done_out and div_by_zero_out pulse 1 cycle after accept; HI=5, LO=0xFFFFFFFF.
- Preload HI=6 LO=7 via a prior op, then MULTU 3*4 with flush_in pulsed at iteration 10 -> busy_out drops next cycle, no done_out, HI=6, LO=7 retained. Op presented with funct 0x20 -> ignored.
- reset driven low mid-DIVU (iteration 15) -> busy_out, done_out, HI and LO all 0 immediately (asynchronous). After release, a new MULTU 2*3 gives LO=6, HI=0.
- With MULDIV_SIGNED_EN:
  - MULT -3*4 -> HI=0xFFFFFFFF, LO=0xFFFFFFF4.
  - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Without the macro, funct 0x1A produces no busy and no done.
